// File: rtl/execute_md_if.sv
// EX-stage operand/control bundle shared by the ID/EX register, hazard unit and execute_md.
// Signal names follow the original flat port list so existing hookups map one-to-one.
interface execute_md_if #(
  parameter int unsigned XLEN = 32
);
  logic            ALUSrcE;
  logic            ALUSrcAE;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] rs1_dataE;
  logic [XLEN-1:0] rs2_dataE;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] ResultW;
  logic [2:0]      funct3E;
  logic            MDStartE;
  logic            FlushE;
  logic [XLEN-1:0] ALUResultE;
  logic [XLEN-1:0] WriteDataE;
  logic [XLEN-1:0] PCTargetE;
  logic            cond_trueE;
  logic            StallMDE;
  logic            MDBusyE;

  modport master (
    output ALUSrcE, ALUSrcAE, ALUControlE, rs1_dataE, rs2_dataE, ImmExtE, PCE,
           ForwardAE, ForwardBE, ALUResultM, ResultW, funct3E, MDStartE, FlushE,
    input  ALUResultE, WriteDataE, PCTargetE, cond_trueE, StallMDE, MDBusyE
  );

  modport slave (
    input  ALUSrcE, ALUSrcAE, ALUControlE, rs1_dataE, rs2_dataE, ImmExtE, PCE,
           ForwardAE, ForwardBE, ALUResultM, ResultW, funct3E, MDStartE, FlushE,
    output ALUResultE, WriteDataE, PCTargetE, cond_trueE, StallMDE, MDBusyE
  );
endinterface

// File: rtl/execute_md.sv
// Execute stage: forwarding, ALU, branch condition and a fixed-latency RV32M mul/div unit
// that stalls the front of the pipe while busy.
module execute_md #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MD_LATENCY = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  execute_md_if.slave     ex
);

  localparam int unsigned CW = $clog2(MD_LATENCY + 1);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLT  = 4'h5,
    ALU_SLTU = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SRL  = 4'h8,
    ALU_SRA  = 4'h9,
    ALU_PASSB = 4'hA
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } md_state_e;

  md_state_e       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] md_a, md_b;
  md_op_e          md_op;
  logic            md_launch;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, md_result;
  alu_op_e         alu_op;
  logic            zero;

  // ---------------- forwarding and ALU ----------------
  always_comb begin
    case (ex.ForwardAE)
      2'b01:   fwd_a = ex.ResultW;
      2'b10:   fwd_a = ex.ALUResultM;
      default: fwd_a = ex.rs1_dataE;
    endcase
    case (ex.ForwardBE)
      2'b01:   fwd_b = ex.ResultW;
      2'b10:   fwd_b = ex.ALUResultM;
      default: fwd_b = ex.rs2_dataE;
    endcase
    src_a = ex.ALUSrcAE ? ex.PCE     : fwd_a;
    src_b = ex.ALUSrcE  ? ex.ImmExtE : fwd_b;
  end

  assign alu_op = alu_op_e'(ex.ALUControlE);

  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_result = src_a + src_b;
      ALU_SUB:   alu_result = src_a - src_b;
      ALU_AND:   alu_result = src_a & src_b;
      ALU_OR:    alu_result = src_a | src_b;
      ALU_XOR:   alu_result = src_a ^ src_b;
      ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:   alu_result = src_a << src_b[SW-1:0];
      ALU_SRL:   alu_result = src_a >> src_b[SW-1:0];
      ALU_SRA:   alu_result = XLEN'($signed(src_a) >>> src_b[SW-1:0]);
      ALU_PASSB: alu_result = src_b;
      default:   alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    case (ex.funct3E)
      3'b000:         ex.cond_trueE = zero;
      3'b001:         ex.cond_trueE = ~zero;
      3'b100, 3'b110: ex.cond_trueE = alu_result[0];
      3'b101, 3'b111: ex.cond_trueE = ~alu_result[0];
      default:        ex.cond_trueE = 1'b0;
    endcase
  end

  assign ex.WriteDataE = fwd_b;
  assign ex.PCTargetE  = ex.PCE + ex.ImmExtE;

  // ---------------- mul/div datapath (latched operands only) ----------------
  // One shared multiplier: operand extension picks signed/unsigned per op.
  logic            sgn_a, sgn_b;
  logic [2*XLEN-1:0] prod;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] quot_s, rem_s, quot_u, rem_u;

  assign sgn_a = md_a[XLEN-1] & ((md_op == MD_MULH) | (md_op == MD_MULHSU));
  assign sgn_b = md_b[XLEN-1] & (md_op == MD_MULH);
  assign prod  = {{XLEN{sgn_a}}, md_a} * {{XLEN{sgn_b}}, md_b};

  assign div_zero = (md_b == '0);
  assign div_ovf  = (md_a == {1'b1, {(XLEN-1){1'b0}}}) && (md_b == '1);
  assign quot_s   = XLEN'($signed(md_a) / $signed(md_b));
  assign rem_s    = XLEN'($signed(md_a) % $signed(md_b));
  assign quot_u   = md_a / md_b;
  assign rem_u    = md_a % md_b;

  always_comb begin
    case (md_op)
      MD_MUL:                       md_result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: md_result = prod[2*XLEN-1:XLEN];
      MD_DIV:  md_result = div_zero ? '1 : (div_ovf ? md_a : quot_s);
      MD_DIVU: md_result = div_zero ? '1 : quot_u;
      MD_REM:  md_result = div_zero ? md_a : (div_ovf ? '0 : rem_s);
      MD_REMU: md_result = div_zero ? md_a : rem_u;
      default: md_result = '0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      md_a  <= '0;
      md_b  <= '0;
      md_op <= MD_MUL;
    end else begin
      state <= state_nxt;
      if (md_launch) begin
        md_a  <= fwd_a;
        md_b  <= fwd_b;
        md_op <= md_op_e'(ex.funct3E);
        cnt   <= CW'(MD_LATENCY);
      end else if (state == S_BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (ex.FlushE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (ex.MDStartE) state_nxt = S_BUSY;
        S_BUSY:  if (cnt == CW'(1)) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Reset gates the launch so a held MDStartE cannot raise the stall while rst is high.
  always_comb begin
    md_launch     = (state == S_IDLE) && ex.MDStartE && !ex.FlushE && !rst;
    ex.StallMDE   = md_launch || ((state == S_BUSY) && !ex.FlushE);
    ex.MDBusyE    = (state == S_BUSY);
    ex.ALUResultE = ((state == S_DONE) && !ex.FlushE) ? md_result : alu_result;
  end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: forwarding/ALU/branch vectors, RV32M ops with latency,
// boundary divides, operand isolation, flush and asynchronous reset.
module tb_execute_md;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  execute_md_if #(.XLEN(32)) ex ();

  execute_md #(.XLEN(32), .MD_LATENCY(32)) dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    ex.ALUControlE = ctl;
    ex.ForwardAE   = fa;
    ex.ForwardBE   = fb;
    ex.rs1_dataE   = a;
    ex.rs2_dataE   = b;
    ex.funct3E     = f3;
  endtask

  // Start an MD op and hold MDStartE through DONE as a stalled pipeline would.
  task automatic md_op(input string tag, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int unsigned cyc;
    @(posedge clk); #1;
    set_ops(ALU_ADD, 2'b00, 2'b00, a, b, f3);
    ex.ALUSrcE = 1'b0; ex.ALUSrcAE = 1'b0;
    ex.MDStartE = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (ex.StallMDE && cyc < 100) begin
      cyc++;
      if (cyc == 6) begin
        ex.rs1_dataE = ~a;
        ex.rs2_dataE = b ^ 32'h5A5A_0F0F;
        ex.funct3E   = ~f3;
      end
      @(negedge clk);
    end
    check({tag, " stall cycles"}, cyc, 32'd33);
    check({tag, " result"}, ex.ALUResultE, exp);
    @(posedge clk); #1 ex.MDStartE = 1'b0;
    @(negedge clk);
    check({tag, " back idle"}, {30'd0, ex.MDBusyE, ex.StallMDE}, 32'd0);
  endtask

  initial begin
    ex.ALUSrcE = 1'b0; ex.ALUSrcAE = 1'b0; ex.ImmExtE = 32'h0; ex.PCE = 32'h0;
    ex.ALUResultM = 32'h0; ex.ResultW = 32'h0; ex.FlushE = 1'b0; ex.MDStartE = 1'b1;
    set_ops(ALU_ADD, 2'b00, 2'b00, 32'd2, 32'd3, 3'b000);
    ex.PCE = 32'h100; ex.ImmExtE = 32'h8;

    // reset state with a start request held
    #3;
    check("rst stall", {31'd0, ex.StallMDE}, 32'd0);
    check("rst busy", {31'd0, ex.MDBusyE}, 32'd0);
    check("rst comb alu", ex.ALUResultE, 32'd5);
    check("rst comb target", ex.PCTargetE, 32'h108);
    ex.MDStartE = 1'b0;
    @(negedge clk); rst = 1'b0;

    // forwarding, ALU and branch conditions
    @(posedge clk); #1;
    ex.ALUResultM = 32'd5;
    set_ops(ALU_SUB, 2'b10, 2'b00, 32'd99, 32'd5, 3'b000);
    @(negedge clk);
    check("beq fwdM cond", {31'd0, ex.cond_trueE}, 32'd1);
    check("beq fwdM alu", ex.ALUResultE, 32'd0);
    ex.funct3E = 3'b001;
    #1 check("bne fwdM cond", {31'd0, ex.cond_trueE}, 32'd0);

    ex.ResultW = 32'h30;
    set_ops(ALU_SUB, 2'b11, 2'b01, 32'h10, 32'h77, 3'b000);
    #1 check("fwdW store data", ex.WriteDataE, 32'h30);
    check("fwdW alu", ex.ALUResultE, 32'hFFFF_FFE0);
    check("fwdW beq cond", {31'd0, ex.cond_trueE}, 32'd0);

    set_ops(ALU_SLT, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 3'b100);
    #1 check("blt cond", {31'd0, ex.cond_trueE}, 32'd1);
    ex.funct3E = 3'b101;
    #1 check("bge cond", {31'd0, ex.cond_trueE}, 32'd0);
    set_ops(ALU_SLTU, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd1, 3'b110);
    #1 check("bltu cond", {31'd0, ex.cond_trueE}, 32'd0);
    ex.funct3E = 3'b010;
    ex.rs1_dataE = 32'd0;
    #1 check("f3 010 cond", {31'd0, ex.cond_trueE}, 32'd0);

    set_ops(ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 3'b000);
    ex.ALUSrcAE = 1'b1; ex.ALUSrcE = 1'b1; ex.PCE = 32'h1000; ex.ImmExtE = 32'h20;
    #1 check("auipc alu", ex.ALUResultE, 32'h1020);
    check("auipc target", ex.PCTargetE, 32'h1020);
    ex.PCE = 32'h10; ex.ImmExtE = 32'hFFFF_FFF0;
    #1 check("target wrap", ex.PCTargetE, 32'h0);
    ex.ALUSrcAE = 1'b0; ex.ALUSrcE = 1'b0;

    // RV32M ops, including divide-by-zero and overflow
    md_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
    md_op("mulh",   3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF);
    md_op("mulhsu", 3'b010, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006);
    md_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_op("div0",   3'b100, 32'h10,       32'h0,         32'hFFFF_FFFF);
    md_op("rem0",   3'b110, 32'h10,       32'h0,         32'h0000_0010);
    md_op("divu0",  3'b101, 32'h10,       32'h0,         32'hFFFF_FFFF);
    md_op("remu0",  3'b111, 32'h10,       32'h0,         32'h0000_0010);
    md_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    md_op("divneg", 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
    md_op("remneg", 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
    md_op("divu",   3'b101, 32'd100,      32'd7,         32'd14);
    md_op("remu",   3'b111, 32'd100,      32'd7,         32'd2);

    // flush at BUSY cycle 5
    @(posedge clk); #1;
    set_ops(ALU_ADD, 2'b00, 2'b00, 32'd3, 32'd4, 3'b000);
    ex.MDStartE = 1'b1;
    repeat (5) @(posedge clk);
    #1 ex.FlushE = 1'b1;
    #1 check("flush stall same cycle", {31'd0, ex.StallMDE}, 32'd0);
    check("flush alu path", ex.ALUResultE, 32'd7);
    @(posedge clk); #1 ex.FlushE = 1'b0; ex.MDStartE = 1'b0;
    @(negedge clk);
    check("flush idle", {30'd0, ex.MDBusyE, ex.StallMDE}, 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("flush no result", ex.ALUResultE, 32'd7);

    // asynchronous reset mid-BUSY
    @(posedge clk); #1 ex.MDStartE = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1 check("async rst busy", {31'd0, ex.MDBusyE}, 32'd0);
    check("async rst stall", {31'd0, ex.StallMDE}, 32'd0);
    check("async rst comb", ex.ALUResultE, 32'd7);
    ex.MDStartE = 1'b0;
    @(negedge clk); rst = 1'b0;
    md_op("mulhu post rst", 3'b011, 32'd3, 32'd4, 32'd0);
    md_op("mul post rst",   3'b000, 32'd3, 32'd4, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
